// File: rtl/score_display_pkg.sv
// Shared constants for the score display: score width, digit count,
// saturation limit, seven-segment codes and the converter state type.
package score_display_pkg;

   localparam int scorelen   = 13;
   localparam int num_digits = 4;
   localparam int sat_limit  = 9999;

   // Segment order {g,f,e,d,c,b,a}, active-high.
   localparam logic [6:0] seg_blank = 7'h00;
   localparam logic [6:0] seg_0     = 7'h3F;
   localparam logic [6:0] seg_1     = 7'h06;
   localparam logic [6:0] seg_2     = 7'h5B;
   localparam logic [6:0] seg_3     = 7'h4F;
   localparam logic [6:0] seg_4     = 7'h66;
   localparam logic [6:0] seg_5     = 7'h6D;
   localparam logic [6:0] seg_6     = 7'h7D;
   localparam logic [6:0] seg_7     = 7'h07;
   localparam logic [6:0] seg_8     = 7'h7F;
   localparam logic [6:0] seg_9     = 7'h6F;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } conv_state_t;

   // BCD digit to segment pattern; non-decimal nibbles show nothing.
   function automatic logic [6:0] seg_enc(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = seg_0;
         4'd1:    s = seg_1;
         4'd2:    s = seg_2;
         4'd3:    s = seg_3;
         4'd4:    s = seg_4;
         4'd5:    s = seg_5;
         4'd6:    s = seg_6;
         4'd7:    s = seg_7;
         4'd8:    s = seg_8;
         4'd9:    s = seg_9;
         default: s = seg_blank;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/score_display_bin2bcd_seq.sv
// Sequential double-dabble converter: one shift per clk3 cycle.
//
// Handshake: start is sampled only while state is ST_IDLE (busy low); the
// cycle it is seen, bin_in is captured and busy rises. busy stays high through
// SHIFT and DONE. done is a one-cycle registered pulse that is high while
// bcd_out holds the finished result; the consumer latches bcd_out on it.
module bin2bcd_seq
   import score_display_pkg::*;
#(
   parameter int SCORE_W = scorelen + 1
) (
   input  logic               clk3,
   input  logic               reset,
   input  logic               start,
   input  logic [SCORE_W-1:0] bin_in,
   output logic [15:0]        bcd_out,
   output logic               busy,
   output logic               done,
   output conv_state_t        state
);

   localparam int CW = $clog2(SCORE_W + 1);

   logic [SCORE_W-1:0] bin_sr;
   logic [15:0]        bcd_sr;
   logic [CW-1:0]      cnt;
   logic [15:0]        bcd_adj;

   assign bcd_out = bcd_sr;

   // Add-3 correction on every nibble that would overflow after doubling.
   always_comb begin
      bcd_adj = bcd_sr;
      for (int i = 0; i < 4; i++) begin
         if (bcd_sr[4*i +: 4] >= 4'd5)
            bcd_adj[4*i +: 4] = bcd_sr[4*i +: 4] + 4'd3;
      end
   end

   // IDLE/SHIFT/DONE conversion FSM with its shift registers and counter.
   always_ff @(posedge clk3 or negedge reset) begin
      if (!reset) begin
         state  <= ST_IDLE;
         bin_sr <= '0;
         bcd_sr <= '0;
         cnt    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               done <= 1'b0;
               if (start) begin
                  bin_sr <= bin_in;
                  bcd_sr <= '0;
                  cnt    <= '0;
                  busy   <= 1'b1;
                  state  <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               bcd_sr <= {bcd_adj[14:0], bin_sr[SCORE_W-1]};
               bin_sr <= bin_sr << 1;
               cnt    <= cnt + 1'b1;
               if (cnt == CW'(SCORE_W - 1)) begin
                  done  <= 1'b1;
                  state <= ST_DONE;
               end
            end
            ST_DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: rtl/score_display.sv
// Score display: detects score changes, converts to BCD with saturation at
// 9999, and scans four common-enable seven-segment digits with leading-zero
// blanking.
module score_display
   import score_display_pkg::*;
#(
   parameter int SCORE_W  = scorelen + 1,
   parameter int SCAN_DIV = 4
) (
   input  logic               clk3,
   input  logic               reset,
   input  logic [SCORE_W-1:0] score,
   output logic [6:0]         seg,
   output logic [3:0]         an,
   output logic               busy
);

   localparam int          DW    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [31:0] SAT32 = 32'(sat_limit);

   logic [SCORE_W-1:0] last_score;
   logic [SCORE_W-1:0] sat_score;
   logic [15:0]        disp_bcd;
   logic [15:0]        conv_bcd;
   logic               conv_done;
   logic               start;
   conv_state_t        conv_state;
   logic [DW-1:0]      div;
   logic [1:0]         idx;
   logic [3:0]         cur_digit;
   logic               blank;

   // A new conversion starts whenever the converter is idle and the score
   // differs from the last one captured; changes while busy are picked up
   // on the next idle cycle.
   assign start = (conv_state == ST_IDLE) && (score != last_score);

   // Clamp to the largest value four digits can show.
   always_comb begin
      sat_score = score;
      if (32'(score) > SAT32)
         sat_score = SCORE_W'(sat_limit);
   end

   bin2bcd_seq #(
      .SCORE_W (SCORE_W)
   ) u_conv (
      .clk3    (clk3),
      .reset   (reset),
      .start   (start),
      .bin_in  (sat_score),
      .bcd_out (conv_bcd),
      .busy    (busy),
      .done    (conv_done),
      .state   (conv_state)
   );

   // Remember the captured score and publish finished conversions atomically.
   always_ff @(posedge clk3 or negedge reset) begin
      if (!reset) begin
         last_score <= '0;
         disp_bcd   <= '0;
      end else begin
         if (start)
            last_score <= score;
         if (conv_done)
            disp_bcd <= conv_bcd;
      end
   end

   // Current digit and leading-zero blanking; the units digit always shows.
   always_comb begin
      cur_digit = disp_bcd[4*idx +: 4];
      case (idx)
         2'd1:    blank = (disp_bcd[15:4]  == 12'h000);
         2'd2:    blank = (disp_bcd[15:8]  == 8'h00);
         2'd3:    blank = (disp_bcd[15:12] == 4'h0);
         default: blank = 1'b0;
      endcase
   end

   // Digit scanner: hold each digit SCAN_DIV cycles, register enable and segments.
   always_ff @(posedge clk3 or negedge reset) begin
      if (!reset) begin
         div <= '0;
         idx <= '0;
         an  <= 4'b0000;
         seg <= seg_blank;
      end else begin
         if (div == DW'(SCAN_DIV - 1)) begin
            div <= '0;
            idx <= idx + 2'd1;
         end else begin
            div <= div + 1'b1;
         end
         an  <= 4'b0001 << idx;
         seg <= blank ? seg_blank : seg_enc(cur_digit);
      end
   end

endmodule
